store_buffer_be: RTL and testbench
==================================

// Module: store_buffer_be
// PURPOSE
//  Next-generation store path for the MEM stage. Decodes SB/SH/SW into byte enables and
//  lane-aligned write data for a parametrised data-bus width, and flags misaligned stores
//  (AdES). Accepted stores queue in a DEPTH-entry FIFO that drains to data memory over a
//  valid/ready handshake. Also reports load-after-store hazards against pending entries.
// PARAMETERS
//  DATA_W  32  memory data-bus width in bits; 32 or 64; BE_W = DATA_W/8
//  ADDR_W  32  byte-address width
//  DEPTH    4  store-buffer entries; power of two, >= 2
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  st_valid   in   1        store request present
//  st_ready   out  1        buffer can accept a request (count < DEPTH)
//  st_op      in   6        opcode: SB=6'b101000, SH=6'b101001, SW=6'b101011
//  st_addr    in   ADDR_W   byte address
//  st_wdata   in   32       GPR store data (rt)
//  st_ades    out  1        misaligned store this cycle (combinational)
//  mem_valid  out  1        head entry presented to memory
//  mem_ready  in   1        memory accepts head entry
//  mem_addr   out  ADDR_W   bus-aligned address (low log2(BE_W) bits zero)
//  mem_wdata  out  DATA_W   lane-shifted write data
//  mem_be     out  BE_W     byte enables
//  ld_valid   in   1        load probing for a hazard
//  ld_addr    in   ADDR_W   load byte address
//  ld_hazard  out  1        load must stall
//  buf_empty  out  1        no pending entries (used by SYSCALL/ERET drain)
// BEHAVIOUR
//  - Reset: pointers=0, count=0, all entries cleared; mem_valid=0, mem_addr/mem_wdata/mem_be=0,
//    buf_empty=1, st_ready=1. Reset takes effect even with a transfer in progress; queued
//    entries are discarded.
//  - Lane gen: off = st_addr[log2(BE_W)-1:0]. SB: be = 1<<off. SH: be = 3<<{off[..1],1'b0}.
//    SW: be = 4'hF << {off[..2],2'b00}. All other opcodes: be = all ones (legacy default),
//    alignment treated as SW. wdata = (st_wdata masked to size) << 8*off_aligned.
//  - Misalign: SH with off[0]=1, or SW/default with off[1:0]!=0 -> st_ades=1 while st_valid.
//    A misaligned request is not enqueued; st_ades does not depend on st_ready.
//  - Enqueue: st_valid & st_ready & !st_ades writes {addr aligned, wdata, be} at wr_ptr on the
//    rising edge. st_ready = (count != DEPTH). When full, a same-cycle dequeue does not
//    reopen st_ready for that cycle.
//  - Drain: mem_valid = (count != 0); mem_* driven from the head entry. A transfer occurs on
//    mem_valid & mem_ready; rd_ptr advances. Head outputs are stable while mem_valid & !mem_ready.
//  - Latency: an entry enqueued in cycle N is on mem_* no earlier than cycle N+1.
//  - Simultaneous enq+deq: count unchanged; both pointers advance; wrap modulo DEPTH.
//  - ld_hazard = ld_valid & (any pending entry, or the store being enqueued this cycle,
//    whose bus-aligned address equals ld_addr's bus-aligned address). The entry leaving on a
//    same-cycle transfer still counts.
//  - Width rules: count is log2(DEPTH)+1 bits; pointers are log2(DEPTH) bits.
// STRUCTURE
//  - Shared package/header: opcode constants (OP_SB/OP_SH/OP_SW), BE_W and OFF_W derivations.
//  - Sub-module store_lane_gen: combinational op/addr/data -> be, shifted data, ades.
//  - Top: FIFO storage, pointers/count, handshake, and the hazard comparator array.
// TESTING
//  - DATA_W=32: SB addr=0x1003 data=0xAB -> be=4'b1000, wdata=0xAB000000, mem_addr=0x1000.
//  - DATA_W=64: SH addr=0x2006 data=0x1234 -> be=8'hC0, wdata=0x1234<<48; SW 0x2004 -> be=8'hF0.
//  - SH addr=0x11 or SW addr=0x2 -> st_ades=1, count unchanged, mem_valid stays 0.
//  - DEPTH=4, mem_ready=0, 5 stores -> st_ready=0 after 4th; release mem_ready -> FIFO order kept.
//  - Enqueue while full with mem_ready=1 -> entry drains, count 4->3, st_ready=1 next cycle.
//  - Pending SW 0x3000; ld 0x3002 -> ld_hazard=1; ld 0x3004 -> 0; reset mid-queue -> buf_empty=1.

Source files
------------

// File: rtl/store_buffer_be_pkg.sv
// Shared definitions for the MEM-stage store buffer: store opcodes,
// access-size decode and bus-width derivations.
package store_buffer_be_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  // Access size class; anything that is not SB/SH/SW is the legacy class
  // (all byte enables, word alignment).
  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_LEGACY = 2'd3
  } st_size_e;

  function automatic int be_w_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic st_size_e decode_size(input logic [5:0] op);
    st_size_e sz;
    case (op)
      OP_SB:   sz = SZ_BYTE;
      OP_SH:   sz = SZ_HALF;
      OP_SW:   sz = SZ_WORD;
      default: sz = SZ_LEGACY;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/store_buffer_be_lane.sv
// Combinational lane generator: turns a store opcode, byte address and GPR
// data into byte enables, lane-shifted write data, bus-aligned address and
// a misalignment flag.
module store_lane_gen
  import store_buffer_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [5:0]          op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   data,
  output logic [ADDR_W-1:0]   addr_al,
  output logic                ades
);

  localparam int BE_W  = be_w_of(DATA_W);
  localparam int OFF_W = off_w_of(DATA_W);

  logic [OFF_W-1:0]  off_s;
  logic [OFF_W-1:0]  off_al_s;
  logic [DATA_W-1:0] raw_s;

  assign off_s   = addr[OFF_W-1:0];
  assign addr_al = addr & ~ADDR_W'(BE_W - 1);
  assign data    = raw_s << {off_al_s, 3'b000};

  // Size decode: pick aligned lane offset, masked data, enables and alignment fault.
  always_comb begin
    off_al_s = off_s;
    raw_s    = '0;
    be       = '0;
    ades     = 1'b0;
    case (decode_size(op))
      SZ_BYTE: begin
        off_al_s = off_s;
        raw_s    = DATA_W'(wdata[7:0]);
        be       = BE_W'(1'b1) << off_al_s;
        ades     = 1'b0;
      end
      SZ_HALF: begin
        off_al_s = {off_s[OFF_W-1:1], 1'b0};
        raw_s    = DATA_W'(wdata[15:0]);
        be       = BE_W'(2'b11) << off_al_s;
        ades     = off_s[0];
      end
      SZ_WORD: begin
        off_al_s = {off_s[OFF_W-1:2], 2'b00};
        raw_s    = DATA_W'(wdata);
        be       = BE_W'(4'hF) << off_al_s;
        ades     = |off_s[1:0];
      end
      default: begin
        // Legacy opcodes write every lane but keep word alignment rules.
        off_al_s = {off_s[OFF_W-1:2], 2'b00};
        raw_s    = DATA_W'(wdata);
        be       = {BE_W{1'b1}};
        ades     = |off_s[1:0];
      end
    endcase
  end

endmodule

// File: rtl/store_buffer_be.sv
// MEM-stage store buffer: accepts lane-decoded stores into a DEPTH-entry
// FIFO, drains the head to data memory over valid/ready, and flags loads
// that hit a pending (or just-accepted) store on the same bus word.
module store_buffer_be
  import store_buffer_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [5:0]          st_op,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [31:0]         st_wdata,
  output logic                st_ades,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                ld_valid,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hazard,
  output logic                buf_empty
);

  localparam int BE_W  = be_w_of(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } entry_t;

  entry_t            ent_r [DEPTH];
  logic [DEPTH-1:0]  pend_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic [BE_W-1:0]   lane_be_s;
  logic [DATA_W-1:0] lane_data_s;
  logic [ADDR_W-1:0] lane_addr_s;
  logic              lane_ades_s;
  logic              enq_s;
  logic              deq_s;
  logic              hit_s;
  logic [ADDR_W-1:0] ld_al_s;

  store_lane_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_lane (
    .op      (st_op),
    .addr    (st_addr),
    .wdata   (st_wdata),
    .be      (lane_be_s),
    .data    (lane_data_s),
    .addr_al (lane_addr_s),
    .ades    (lane_ades_s)
  );

  assign st_ades   = st_valid & lane_ades_s;
  assign st_ready  = (count_r != CNT_W'(DEPTH));
  assign enq_s     = st_valid & st_ready & ~lane_ades_s;
  assign mem_valid = (count_r != {CNT_W{1'b0}});
  assign buf_empty = (count_r == {CNT_W{1'b0}});
  assign deq_s     = mem_valid & mem_ready;
  assign mem_addr  = ent_r[rd_ptr_r].addr;
  assign mem_wdata = ent_r[rd_ptr_r].data;
  assign mem_be    = ent_r[rd_ptr_r].be;
  assign ld_al_s   = ld_addr & ~ADDR_W'(BE_W - 1);
  assign ld_hazard = ld_valid & hit_s;

  // Hazard comparator array over pending entries plus the store accepted this cycle.
  always_comb begin
    hit_s = enq_s & (lane_addr_s == ld_al_s);
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (pend_r[i] & (ent_r[i].addr == ld_al_s));
    end
  end

  // FIFO storage, pointers, occupancy and per-entry pending flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
      pend_r   <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        ent_r[wr_ptr_r] <= '{addr: lane_addr_s, data: lane_data_s, be: lane_be_s};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_s && (wr_ptr_r == PTR_W'(i))) begin
          pend_r[i] <= 1'b1;
        end else if (deq_s && (rd_ptr_r == PTR_W'(i))) begin
          pend_r[i] <= 1'b0;
        end
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_be.sv
// Self-checking bench: a 32-bit and a 64-bit store buffer share one stimulus
// stream and are compared against a queue-based reference model.
module tb_store_buffer_be;
  import store_buffer_be_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [5:0]  st_op = 6'd0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_wdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'd0;

  logic        st_ready_32, st_ades_32, mem_valid_32, ld_hazard_32, buf_empty_32;
  logic [31:0] mem_addr_32, mem_wdata_32;
  logic [3:0]  mem_be_32;
  logic        st_ready_64, st_ades_64, mem_valid_64, ld_hazard_64, buf_empty_64;
  logic [31:0] mem_addr_64;
  logic [63:0] mem_wdata_64;
  logic [7:0]  mem_be_64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  st_t q[$];

  always #5 clk = ~clk;

  store_buffer_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready_32),
    .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata), .st_ades(st_ades_32),
    .mem_valid(mem_valid_32), .mem_ready(mem_ready), .mem_addr(mem_addr_32),
    .mem_wdata(mem_wdata_32), .mem_be(mem_be_32), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard_32), .buf_empty(buf_empty_32)
  );

  store_buffer_be #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready_64),
    .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata), .st_ades(st_ades_64),
    .mem_valid(mem_valid_64), .mem_ready(mem_ready), .mem_addr(mem_addr_64),
    .mem_wdata(mem_wdata_64), .mem_be(mem_be_64), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard_64), .buf_empty(buf_empty_64)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (size/offset arithmetic) ----------------
  function automatic int size_of(input logic [5:0] op);
    if (op == OP_SB) return 1;
    else if (op == OP_SH) return 2;
    else return 4;
  endfunction

  function automatic bit is_legacy(input logic [5:0] op);
    return (op != OP_SB) && (op != OP_SH) && (op != OP_SW);
  endfunction

  function automatic int lane_off(input logic [5:0] op, input logic [31:0] a, input int bew);
    int off;
    off = int'(a % 32'(bew));
    return off - (off % size_of(op));
  endfunction

  function automatic logic [7:0] exp_be(input logic [5:0] op, input logic [31:0] a, input int bew);
    logic [15:0] m;
    if (is_legacy(op)) return (bew == 8) ? 8'hFF : 8'h0F;
    m = 16'((1 << size_of(op)) - 1) << lane_off(op, a, bew);
    return m[7:0];
  endfunction

  function automatic logic [63:0] exp_data(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] d, input int bew);
    logic [63:0] v;
    case (size_of(op))
      1:       v = {56'd0, d[7:0]};
      2:       v = {48'd0, d[15:0]};
      default: v = {32'd0, d};
    endcase
    return v << (8 * lane_off(op, a, bew));
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a, input int bew);
    return a - (a % 32'(bew));
  endfunction

  task automatic drive(input bit v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input bit mr, input bit lv, input logic [31:0] la);
    st_valid = v; st_op = op; st_addr = a; st_wdata = d;
    mem_ready = mr; ld_valid = lv; ld_addr = la;
  endtask

  // One clock: drive, compare every output with the model, advance the model.
  task automatic step(input bit v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] d, input bit mr, input bit lv, input logic [31:0] la);
    bit exp_rdy, mis, enq, deq, h32, h64;
    st_t s;
    drive(v, op, a, d, mr, lv, la);
    #1;
    exp_rdy = (q.size() < DEPTH);
    mis     = (a % 32'(size_of(op))) != 32'd0;
    enq     = v && exp_rdy && !mis;
    deq     = (q.size() != 0) && mr;
    check_val("st_ready32", st_ready_32, exp_rdy);
    check_val("st_ready64", st_ready_64, exp_rdy);
    check_val("st_ades32", st_ades_32, v && mis);
    check_val("st_ades64", st_ades_64, v && mis);
    check_val("mem_valid32", mem_valid_32, q.size() != 0);
    check_val("mem_valid64", mem_valid_64, q.size() != 0);
    check_val("buf_empty32", buf_empty_32, q.size() == 0);
    check_val("buf_empty64", buf_empty_64, q.size() == 0);
    if (q.size() != 0) begin
      s = q[0];
      check_val("mem_addr32", mem_addr_32, align(s.addr, 4));
      check_val("mem_be32", mem_be_32, exp_be(s.op, s.addr, 4));
      check_val("mem_wdata32", mem_wdata_32, exp_data(s.op, s.addr, s.data, 4));
      check_val("mem_addr64", mem_addr_64, align(s.addr, 8));
      check_val("mem_be64", mem_be_64, exp_be(s.op, s.addr, 8));
      check_val("mem_wdata64", mem_wdata_64, exp_data(s.op, s.addr, s.data, 8));
    end
    h32 = 1'b0;
    h64 = 1'b0;
    if (lv) begin
      foreach (q[i]) begin
        h32 |= (align(q[i].addr, 4) == align(la, 4));
        h64 |= (align(q[i].addr, 8) == align(la, 8));
      end
      if (enq) begin
        h32 |= (align(a, 4) == align(la, 4));
        h64 |= (align(a, 8) == align(la, 8));
      end
    end
    check_val("ld_hazard32", ld_hazard_32, h32);
    check_val("ld_hazard64", ld_hazard_64, h64);
    if (deq) void'(q.pop_front());
    if (enq) begin
      s.op = op; s.addr = a; s.data = d;
      q.push_back(s);
    end
    @(negedge clk);
  endtask

  // Synchronous reset with a store and a transfer both requested.
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, OP_SW, 32'h3000, 32'h5555AAAA, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    q.delete();
    #1;
    check_val("rst_buf_empty32", buf_empty_32, 1'b1);
    check_val("rst_buf_empty64", buf_empty_64, 1'b1);
    check_val("rst_st_ready32", st_ready_32, 1'b1);
    check_val("rst_mem_valid32", mem_valid_32, 1'b0);
    check_val("rst_mem_valid64", mem_valid_64, 1'b0);
    check_val("rst_mem_addr32", mem_addr_32, 32'd0);
    check_val("rst_mem_wdata64", mem_wdata_64, 64'd0);
    check_val("rst_mem_be32", mem_be_32, 4'd0);
    check_val("rst_mem_be64", mem_be_64, 8'd0);
  endtask

  initial begin
    logic [5:0]  rop;
    logic [31:0] raddr;
    int          rdy_pct;

    @(negedge clk);
    do_reset();

    // SB to byte 3: top lane on the 32-bit bus, lane 3 on the 64-bit bus.
    step(1'b1, OP_SB, 32'h1003, 32'h000000AB, 1'b0, 1'b0, 32'd0);
    #1;
    check_val("sb_be32", mem_be_32, 4'b1000);
    check_val("sb_wdata32", mem_wdata_32, 32'hAB000000);
    check_val("sb_addr32", mem_addr_32, 32'h1000);
    check_val("sb_be64", mem_be_64, 8'h08);
    step(1'b0, OP_SB, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);

    // SH at 0x2006 then SW at 0x2004 on the 64-bit bus.
    step(1'b1, OP_SH, 32'h2006, 32'h00001234, 1'b0, 1'b0, 32'd0);
    #1;
    check_val("sh_be64", mem_be_64, 8'hC0);
    check_val("sh_wdata64", mem_wdata_64, 64'h1234_0000_0000_0000);
    check_val("sh_addr64", mem_addr_64, 32'h2000);
    step(1'b1, OP_SW, 32'h2004, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
    #1;
    check_val("sw_be64", mem_be_64, 8'hF0);
    check_val("sw_wdata64", mem_wdata_64, 64'hDEADBEEF_0000_0000);
    step(1'b0, OP_SW, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);

    // Misaligned SH and SW: flagged, not queued.
    drive(1'b1, OP_SH, 32'h11, 32'h1, 1'b0, 1'b0, 32'd0);
    #1;
    check_val("ades_sh", st_ades_32, 1'b1);
    step(1'b1, OP_SH, 32'h11, 32'h1, 1'b0, 1'b0, 32'd0);
    drive(1'b1, OP_SW, 32'h2, 32'h1, 1'b0, 1'b0, 32'd0);
    #1;
    check_val("ades_sw", st_ades_64, 1'b1);
    step(1'b1, OP_SW, 32'h2, 32'h1, 1'b0, 1'b0, 32'd0);
    #1;
    check_val("ades_no_enq", mem_valid_32, 1'b0);

    // Fill with memory stalled, fifth store refused.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_SW, 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0, 32'd0);
    end
    #1;
    check_val("full_ready", st_ready_32, 1'b0);
    // Store while full with memory ready: head drains, store still refused this cycle.
    step(1'b1, OP_SW, 32'h5000, 32'h5, 1'b1, 1'b0, 32'd0);
    #1;
    check_val("reopen_ready", st_ready_32, 1'b1);
    check_val("reopen_head", mem_addr_32, 32'h4004);
    for (int i = 0; i < 3; i++) step(1'b0, OP_SW, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);

    // Load-after-store hazard on bus-word granularity.
    step(1'b1, OP_SW, 32'h3000, 32'h77, 1'b0, 1'b0, 32'd0);
    drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3002);
    #1;
    check_val("haz_3002", ld_hazard_32, 1'b1);
    drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3004);
    #1;
    check_val("haz_3004_32", ld_hazard_32, 1'b0);
    check_val("haz_3004_64", ld_hazard_64, 1'b1);
    step(1'b0, OP_SW, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3004);

    // Reset with entries queued.
    step(1'b1, OP_SB, 32'h3001, 32'h12, 1'b0, 1'b0, 32'd0);
    do_reset();

    // Randomized traffic in phases of varying memory back-pressure.
    for (int ph = 0; ph < 6; ph++) begin
      rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 50 : 90);
      for (int n = 0; n < 400; n++) begin
        case ($urandom_range(0, 3))
          0:       rop = OP_SB;
          1:       rop = OP_SH;
          2:       rop = OP_SW;
          default: rop = 6'b100011;
        endcase
        raddr = 32'h3000 + 32'($urandom_range(0, 47));
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          step($urandom_range(0, 3) != 0, rop, raddr, $urandom,
               $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 1) == 1,
               32'h3000 + 32'($urandom_range(0, 47)));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
